// File: rtl/ds_fifo_mc_if.sv
// ds_fifo_mc_if -- bundle of all non-clock signals of the multi-channel ds FIFO.
//   Write side : i_wr_data (CHANNELS*DATA_W), i_wr_vld, o_wr_rdy (CHANNELS each)
//   Read side  : o_rd_data (DATA_W), o_rd_ch (CH_W), o_rd_vld, i_rd_rdy
//   Status     : i_lvl_thr (LVL_W), o_lvl (CHANNELS*LVL_W), o_thr (CHANNELS)
//   Optional   : o_hwm (CHANNELS*LVL_W) when DS_FIFO_MC_HWM_EN is defined
// Modports: master = producers/consumer/monitor side, slave = the FIFO.
interface ds_fifo_mc_if #(
    parameter int DATA_W   = 8,
    parameter int CAPACITY = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LVL_W    = $clog2(CAPACITY + 1)
);
    logic [CHANNELS*DATA_W-1:0] i_wr_data;
    logic [CHANNELS-1:0]        i_wr_vld;
    logic [CHANNELS-1:0]        o_wr_rdy;
    logic [DATA_W-1:0]          o_rd_data;
    logic [CH_W-1:0]            o_rd_ch;
    logic                       o_rd_vld;
    logic                       i_rd_rdy;
    logic [LVL_W-1:0]           i_lvl_thr;
    logic [CHANNELS*LVL_W-1:0]  o_lvl;
    logic [CHANNELS-1:0]        o_thr;
`ifdef DS_FIFO_MC_HWM_EN
    logic [CHANNELS*LVL_W-1:0]  o_hwm;

    modport master (
        output i_wr_data, i_wr_vld, i_rd_rdy, i_lvl_thr,
        input  o_wr_rdy, o_rd_data, o_rd_ch, o_rd_vld, o_lvl, o_thr, o_hwm
    );
    modport slave (
        input  i_wr_data, i_wr_vld, i_rd_rdy, i_lvl_thr,
        output o_wr_rdy, o_rd_data, o_rd_ch, o_rd_vld, o_lvl, o_thr, o_hwm
    );
`else
    modport master (
        output i_wr_data, i_wr_vld, i_rd_rdy, i_lvl_thr,
        input  o_wr_rdy, o_rd_data, o_rd_ch, o_rd_vld, o_lvl, o_thr
    );
    modport slave (
        input  i_wr_data, i_wr_vld, i_rd_rdy, i_lvl_thr,
        output o_wr_rdy, o_rd_data, o_rd_ch, o_rd_vld, o_lvl, o_thr
    );
`endif
endinterface

// File: rtl/ds_fifo_mc.sv
// ds_fifo_mc -- CHANNELS independent FIFO queues merged onto one read port
// through a round-robin arbiter; every output beat carries its channel tag.
// Ports:
//   i_clk  clock (rising edge)
//   i_rst  asynchronous active-low reset
//   bus    ds_fifo_mc_if.slave (per-channel write ports, merged read port,
//          per-channel level / threshold status)
// Optional feature macro: DS_FIFO_MC_HWM_EN adds per-channel high-water mark
// output o_hwm (max level since reset).

// One queue: storage, wrap-compare pointers and level counter.
module ds_fifo_mc_ch #(
    parameter int DATA_W   = 8,
    parameter int CAPACITY = 8,
    parameter int LVL_W    = $clog2(CAPACITY + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_vld_i,
    input  logic              pop_i,       // only asserted when level != 0
    output logic              wr_rdy_o,
    output logic [DATA_W-1:0] head_o,
    output logic [LVL_W-1:0]  lvl_o
`ifdef DS_FIFO_MC_HWM_EN
  , output logic [LVL_W-1:0]  hwm_o
`endif
);
    localparam int               PTR_W = $clog2(CAPACITY);
    localparam logic [LVL_W-1:0] FULL  = LVL_W'(CAPACITY);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(CAPACITY - 1);

    logic [DATA_W-1:0] mem_q [CAPACITY];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              push;

    // Readiness comes from the level register alone, so a full queue
    // refuses a write even when it is popped in the same cycle.
    assign wr_rdy_o = (lvl_q != FULL);
    assign push     = wr_vld_i & wr_rdy_o;
    assign head_o   = mem_q[rptr_q];
    assign lvl_o    = lvl_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        lvl_d  = lvl_q;
        if (push)  wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PTR_W'(1);
        if (pop_i) rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PTR_W'(1);
        if (push & ~pop_i)      lvl_d = lvl_q + LVL_W'(1);
        else if (~push & pop_i) lvl_d = lvl_q - LVL_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wr_data_i;
    end

`ifdef DS_FIFO_MC_HWM_EN
    logic [LVL_W-1:0] hwm_q;
    // Tracks the next level so the mark moves in the same cycle as lvl_q;
    // level never exceeds CAPACITY, so the mark saturates there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              hwm_q <= '0;
        else if (lvl_d > hwm_q)   hwm_q <= lvl_d;
    end
    assign hwm_o = hwm_q;
`endif
endmodule

module ds_fifo_mc #(
    parameter int DATA_W   = 8,
    parameter int CAPACITY = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LVL_W    = $clog2(CAPACITY + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ds_fifo_mc_if.slave  bus
);
    logic [CHANNELS-1:0]             elig, pop;
    logic [CHANNELS-1:0][DATA_W-1:0] head;
    logic [CHANNELS-1:0][LVL_W-1:0]  lvl;
`ifdef DS_FIFO_MC_HWM_EN
    logic [CHANNELS-1:0][LVL_W-1:0]  hwm;
`endif
    logic [CH_W-1:0] last_q, last_d, lock_ch_q, lock_ch_d, rr_ch, pick;
    logic            lock_q, lock_d, any, xfer;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ds_fifo_mc_ch #(.DATA_W(DATA_W), .CAPACITY(CAPACITY), .LVL_W(LVL_W)) u_ch (
            .clk_i     (i_clk),
            .rst_ni    (i_rst),
            .wr_data_i (bus.i_wr_data[c*DATA_W +: DATA_W]),
            .wr_vld_i  (bus.i_wr_vld[c]),
            .pop_i     (pop[c]),
            .wr_rdy_o  (bus.o_wr_rdy[c]),
            .head_o    (head[c]),
            .lvl_o     (lvl[c])
`ifdef DS_FIFO_MC_HWM_EN
          , .hwm_o     (hwm[c])
`endif
        );
        assign elig[c]      = (lvl[c] != '0);
        assign pop[c]       = xfer && (pick == CH_W'(c));
        // Threshold 0 makes every compare true, giving all ones.
        assign bus.o_thr[c] = (lvl[c] >= bus.i_lvl_thr);
    end

    assign bus.o_lvl = lvl;
`ifdef DS_FIFO_MC_HWM_EN
    assign bus.o_hwm = hwm;
`endif

    // First eligible channel after last_q in ascending modulo order.
    always_comb begin : p_rr
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        rr_ch = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(last_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                rr_ch = CH_W'(idx);
            end
        end
    end

    // A stalled offer holds its channel; the locked channel cannot drain
    // without a transfer, so it stays eligible for the whole stall.
    assign pick      = lock_q ? lock_ch_q : rr_ch;
    assign any       = |elig;
    assign xfer      = any & bus.i_rd_rdy;
    assign lock_d    = any & ~bus.i_rd_rdy;
    assign lock_ch_d = pick;
    assign last_d    = xfer ? pick : last_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_q    <= CH_W'(CHANNELS - 1);
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign bus.o_rd_vld  = any;
    assign bus.o_rd_ch   = any ? pick : '0;
    assign bus.o_rd_data = any ? head[pick] : '0;
endmodule

// File: tb/tb_ds_fifo_mc.sv
module tb_ds_fifo_mc;
    localparam int DW = 8, CAP = 8, NCH = 4, LW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ds_fifo_mc_if #(.DATA_W(DW), .CAPACITY(CAP), .CHANNELS(NCH)) bus ();
    ds_fifo_mc #(.DATA_W(DW), .CAPACITY(CAP), .CHANNELS(NCH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous pulse placed between clock edges.
    task automatic rst_pulse;
        bus.i_wr_vld = '0;
        bus.i_rd_rdy = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic push1(input int c, input logic [7:0] d);
        bus.i_wr_data[c*DW +: DW] = d;
        bus.i_wr_vld[c] = 1'b1;
        tick();
        bus.i_wr_vld[c] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.i_wr_vld = '0; bus.i_wr_data = '0; bus.i_rd_rdy = 1'b0; bus.i_lvl_thr = 4'd3;
        #1;
        n_tests++; if (bus.o_lvl !== '0) begin n_fail++; $display("FAIL reset_lvl got %h want 0", bus.o_lvl); end
        n_tests++; if (bus.o_wr_rdy !== 4'hF) begin n_fail++; $display("FAIL reset_wr_rdy got %b want 1111", bus.o_wr_rdy); end
        n_tests++; if (bus.o_rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_vld got %b want 0", bus.o_rd_vld); end
        n_tests++; if (bus.o_rd_ch !== 2'd0) begin n_fail++; $display("FAIL reset_rd_ch got %0d want 0", bus.o_rd_ch); end
        n_tests++; if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", bus.o_rd_data); end
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full;
        rst_pulse();
        for (int i = 0; i < 8; i++) push1(0, 8'(8'h10 + i));
        n_tests++; if (bus.o_wr_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_wr_rdy got %b want 0", bus.o_wr_rdy[0]); end
        n_tests++; if (bus.o_lvl[0 +: LW] !== 4'd8) begin n_fail++; $display("FAIL full_lvl got %0d want 8", bus.o_lvl[0 +: LW]); end
        push1(0, 8'hFF);
        n_tests++; if (bus.o_lvl[0 +: LW] !== 4'd8) begin n_fail++; $display("FAIL full_refuse_lvl got %0d want 8", bus.o_lvl[0 +: LW]); end
        bus.i_rd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (bus.o_rd_vld !== 1'b1 || bus.o_rd_ch !== 2'd0 || bus.o_rd_data !== 8'(8'h10 + i)) begin
                n_fail++; $display("FAIL full_drain[%0d] got vld=%b ch=%0d data=%h want 1/0/%h", i, bus.o_rd_vld, bus.o_rd_ch, bus.o_rd_data, 8'(8'h10 + i));
            end
            tick();
        end
        n_tests++; if (bus.o_rd_vld !== 1'b0) begin n_fail++; $display("FAIL full_empty_vld got %b want 0", bus.o_rd_vld); end
        bus.i_rd_rdy = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [7:0] exp;
        rst_pulse();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) bus.i_wr_data[c*DW +: DW] = 8'(8'h40 + c*16 + k);
            bus.i_wr_vld = 4'hF;
            tick();
        end
        bus.i_wr_vld = '0;
        n_tests++; if (bus.o_lvl !== 16'h2222) begin n_fail++; $display("FAIL rr_preload_lvl got %h want 2222", bus.o_lvl); end
        bus.i_rd_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) begin
                exp = 8'(8'h40 + c*16 + r);
                n_tests++; if (bus.o_rd_vld !== 1'b1 || bus.o_rd_ch !== 2'(c) || bus.o_rd_data !== exp) begin
                    n_fail++; $display("FAIL rr_seq[%0d] got vld=%b ch=%0d data=%h want 1/%0d/%h", r*NCH + c, bus.o_rd_vld, bus.o_rd_ch, bus.o_rd_data, c, exp);
                end
                tick();
            end
        end
        n_tests++; if (bus.o_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rr_after_vld got %b want 0", bus.o_rd_vld); end
        bus.i_rd_rdy = 1'b0;
    endtask

    task automatic test_stall;
        rst_pulse();
        push1(2, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.o_rd_vld !== 1'b1 || bus.o_rd_ch !== 2'd2 || bus.o_rd_data !== 8'hA5) begin
                n_fail++; $display("FAIL stall_hold[%0d] got vld=%b ch=%0d data=%h want 1/2/a5", i, bus.o_rd_vld, bus.o_rd_ch, bus.o_rd_data);
            end
            tick();
        end
        push1(0, 8'h3C);
        n_tests++; if (bus.o_rd_ch !== 2'd2 || bus.o_rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL stall_lock got ch=%0d data=%h want 2/a5", bus.o_rd_ch, bus.o_rd_data);
        end
        bus.i_rd_rdy = 1'b1;
        tick();
        n_tests++; if (bus.o_rd_vld !== 1'b1 || bus.o_rd_ch !== 2'd0 || bus.o_rd_data !== 8'h3C) begin
            n_fail++; $display("FAIL stall_next got vld=%b ch=%0d data=%h want 1/0/3c", bus.o_rd_vld, bus.o_rd_ch, bus.o_rd_data);
        end
        tick();
        n_tests++; if (bus.o_rd_vld !== 1'b0) begin n_fail++; $display("FAIL stall_empty_vld got %b want 0", bus.o_rd_vld); end
        bus.i_rd_rdy = 1'b0;
    endtask

    task automatic test_wrap;
        logic [7:0] exp;
        rst_pulse();
        for (int i = 0; i < 8; i++) push1(3, 8'(8'h30 + i));
        bus.i_wr_data[3*DW +: DW] = 8'h55;
        bus.i_wr_vld[3] = 1'b1;
        bus.i_rd_rdy = 1'b1;
        n_tests++; if (bus.o_wr_rdy[3] !== 1'b0 || bus.o_rd_data !== 8'h30) begin
            n_fail++; $display("FAIL wrap_full got rdy=%b data=%h want 0/30", bus.o_wr_rdy[3], bus.o_rd_data);
        end
        tick();
        n_tests++; if (bus.o_lvl[3*LW +: LW] !== 4'd7) begin n_fail++; $display("FAIL wrap_lvl1 got %0d want 7", bus.o_lvl[3*LW +: LW]); end
        n_tests++; if (bus.o_wr_rdy[3] !== 1'b1 || bus.o_rd_data !== 8'h31) begin
            n_fail++; $display("FAIL wrap_rw got rdy=%b data=%h want 1/31", bus.o_wr_rdy[3], bus.o_rd_data);
        end
        tick();
        bus.i_wr_vld[3] = 1'b0;
        n_tests++; if (bus.o_lvl[3*LW +: LW] !== 4'd7) begin n_fail++; $display("FAIL wrap_lvl2 got %0d want 7", bus.o_lvl[3*LW +: LW]); end
        for (int i = 0; i < 7; i++) begin
            exp = (i < 6) ? 8'(8'h32 + i) : 8'h55;
            n_tests++; if (bus.o_rd_vld !== 1'b1 || bus.o_rd_ch !== 2'd3 || bus.o_rd_data !== exp) begin
                n_fail++; $display("FAIL wrap_drain[%0d] got vld=%b ch=%0d data=%h want 1/3/%h", i, bus.o_rd_vld, bus.o_rd_ch, bus.o_rd_data, exp);
            end
            tick();
        end
        n_tests++; if (bus.o_rd_vld !== 1'b0) begin n_fail++; $display("FAIL wrap_empty_vld got %b want 0", bus.o_rd_vld); end
        bus.i_rd_rdy = 1'b0;
    endtask

    task automatic test_threshold;
        logic exp;
        rst_pulse();
        bus.i_lvl_thr = 4'd3;
        for (int k = 0; k < 4; k++) begin
            push1(1, 8'(8'h60 + k));
            exp = (k + 1 >= 3);
            n_tests++; if (bus.o_thr[1] !== exp) begin n_fail++; $display("FAIL thr_write[%0d] got %b want %b", k, bus.o_thr[1], exp); end
        end
        bus.i_rd_rdy = 1'b1;
        tick();
        n_tests++; if (bus.o_thr[1] !== 1'b1) begin n_fail++; $display("FAIL thr_read1 got %b want 1", bus.o_thr[1]); end
        tick();
        bus.i_rd_rdy = 1'b0;
        n_tests++; if (bus.o_thr[1] !== 1'b0) begin n_fail++; $display("FAIL thr_read2 got %b want 0", bus.o_thr[1]); end
        n_tests++; if (bus.o_lvl[1*LW +: LW] !== 4'd2) begin n_fail++; $display("FAIL thr_lvl got %0d want 2", bus.o_lvl[1*LW +: LW]); end
`ifdef DS_FIFO_MC_HWM_EN
        n_tests++; if (bus.o_hwm[1*LW +: LW] !== 4'd4) begin n_fail++; $display("FAIL hwm_ch1 got %0d want 4", bus.o_hwm[1*LW +: LW]); end
`endif
        bus.i_lvl_thr = 4'd0;
        #1;
        n_tests++; if (bus.o_thr !== 4'hF) begin n_fail++; $display("FAIL thr_zero got %b want 1111", bus.o_thr); end
        bus.i_lvl_thr = 4'd3;
    endtask

    task automatic test_reset_mid;
        rst_pulse();
        for (int i = 0; i < 3; i++) push1(1, 8'(8'h70 + i));
        n_tests++; if (bus.o_lvl[1*LW +: LW] !== 4'd3) begin n_fail++; $display("FAIL rstmid_pre_lvl got %0d want 3", bus.o_lvl[1*LW +: LW]); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus.o_lvl !== '0 || bus.o_rd_vld !== 1'b0 || bus.o_wr_rdy !== 4'hF) begin
            n_fail++; $display("FAIL rstmid_now got lvl=%h vld=%b rdy=%b want 0/0/1111", bus.o_lvl, bus.o_rd_vld, bus.o_wr_rdy);
        end
        #1;
        rst = 1'b1;
        bus.i_rd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (bus.o_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_beat[%0d] got vld=%b data=%h want 0", i, bus.o_rd_vld, bus.o_rd_data); end
        end
        bus.i_rd_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full();
        test_round_robin();
        test_stall();
        test_wrap();
        test_threshold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ds_fifo_mc.md
Name: ds_fifo_mc

Overview:
- Multi-channel successor of the single-queue ds stream FIFO.
- Provides CHANNELS independent FIFO queues, each with its own ds write port (FC_BI valid/ready) and level/threshold status.
- All queues drain through one merged ds read port, selected by a fair round-robin arbiter; each output beat is tagged with its source channel.
- Sits between several producers (e.g. per-lane packet sources) and a single consumer.

Parameters:
- DATA_W, 8, width of one data beat.
- CAPACITY, 8, entries per channel; any value >= 2, not restricted to powers of two.
- CHANNELS, 4, number of queues; >= 1.
- CH_W, $clog2(CHANNELS) (minimum 1), derived width of the channel tag.
- LVL_W, $clog2(CAPACITY+1), derived width of a level value.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_wr_data  in  CHANNELS*DATA_W  write data; channel c occupies bits [c*DATA_W +: DATA_W].
- i_wr_vld  in  CHANNELS  per-channel write valid.
- o_wr_rdy  out  CHANNELS  per-channel write ready.
- o_rd_data  out  DATA_W  head beat of the granted channel.
- o_rd_ch  out  CH_W  index of the granted channel.
- o_rd_vld  out  1  read valid.
- i_rd_rdy  in  1  read ready.
- i_lvl_thr  in  LVL_W  level threshold, shared by all channels.
- o_lvl  out  CHANNELS*LVL_W  per-channel fill level, 0..CAPACITY.
- o_thr  out  CHANNELS  per-channel flag: level >= i_lvl_thr.

Behaviour:
- Reset, asserted asynchronously while i_rst=0:
  - all levels and read/write pointers = 0; o_lvl = 0.
  - o_wr_rdy = all ones; o_rd_vld = 0; o_rd_ch = 0; o_rd_data = 0.
  - grant lock cleared; round-robin last-grant pointer = CHANNELS-1, so channel 0 has first priority.
  - Storage contents are not reset.
- Reset release is synchronous to i_clk. Reset mid-operation discards all queued data; no beat is delivered after reset.
- Write:
  - A beat is accepted on channel c when i_wr_vld[c] & o_wr_rdy[c] at a clock edge.
  - o_wr_rdy[c] = (lvl[c] != CAPACITY) and is driven from registered state only.
  - A full channel never accepts a write, even if a read of that channel occurs in the same cycle (no write-through when full).
- Per-channel pointers wrap from CAPACITY-1 to 0. The implementation uses explicit wrap compare, not a power-of-two mask.
- Write-to-read latency is 1 cycle: a beat accepted at edge N can appear on o_rd_data after edge N.
- Read arbitration:
  - Eligible channels are those with lvl != 0.
  - Combinational round-robin pick: first eligible channel after the last-granted pointer, in ascending modulo order.
  - o_rd_vld = 1 when any channel is eligible.
  - o_rd_data and o_rd_ch reflect the picked channel's head.
- Read handshake:
  - A beat transfers when o_rd_vld & i_rd_rdy; that channel's read pointer advances, its level decrements, and last-grant = that channel.
- Stall stability (FC_BI rule):
  - If o_rd_vld=1 and i_rd_rdy=0, the grant is locked. o_rd_ch and o_rd_data stay unchanged until the transfer completes, even if other channels become eligible.
  - o_rd_vld never deasserts without a transfer.
- Simultaneous write and read on the same channel: level unchanged, both pointers advance.
- Empty channel with a write and no read: level becomes 1 and the channel is eligible next cycle.
- o_lvl and o_thr are registered-state derived, with no combinational path from any input except i_lvl_thr to o_thr.
- Threshold edge case: i_lvl_thr = 0 forces o_thr to all ones.

Optional Feature:
- Macro: DS_FIFO_MC_HWM_EN.
- When defined:
  - Extra output o_hwm, CHANNELS*LVL_W: per-channel high-water mark, the maximum level reached since reset.
  - Updates in the same cycle the level register updates and is cleared only by i_rst.
  - Saturates at CAPACITY.
- When undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill ch1 with 3 beats, assert i_rst=0 for 1 cycle without a clock edge.
  - Required: o_lvl=0, o_rd_vld=0, o_wr_rdy=4'b1111 immediately; no old beat is ever output.
- Full boundary:
  - Stimulus: write 8 beats 0x10..0x17 to ch0 with i_rd_rdy=0.
  - Required: o_wr_rdy[0]=0 and lvl0=8 after the 8th edge; a 9th beat 0xFF is refused.
  - Then drain: output order is 0x10..0x17, o_rd_ch=0 throughout.
- Round-robin fairness:
  - Stimulus: preload 2 beats each in ch0..ch3, hold i_rd_rdy=1.
  - Required: o_rd_ch sequence 0,1,2,3,0,1,2,3; o_rd_vld=0 afterwards.
- Stall stability:
  - Stimulus: ch2 holds 0xA5, i_rd_rdy=0 for 5 cycles, then write 0x3C to ch0.
  - Required: o_rd_ch=2, o_rd_data=0xA5 unchanged until i_rd_rdy=1; the next beat is from ch0 (0x3C).
- Concurrent read/write at wrap:
  - Stimulus: ch3 at level 8; read and write (0x55) on ch3 in the same cycle.
  - Required: the write is refused (o_wr_rdy[3]=0) and the level becomes 7.
  - Next cycle: read and write together; the level stays 7 and 0x55 is eventually output after the pointer wraps.
- Threshold and HWM:
  - Stimulus: i_lvl_thr=3, write 4 beats to ch1, read 2.
  - Required: o_thr[1] rises after the 3rd write and falls after the 2nd read.
  - With DS_FIFO_MC_HWM_EN: o_hwm ch1 = 4.
